// File: rtl/mac_dot_seq.sv
// Framed dot-product sequencer around a 16x16 unsigned multiply-accumulate datapath.
// A start with a length opens a frame; the block accumulates that many pairs and holds the sum until taken.
module mac_dot_seq #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 64,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              busy,
  output logic [LEN_W-1:0]  beat_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and result stays put while out_valid is high.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [LEN_W-1:0]    len_q;
  logic [2*DATA_W-1:0] prod;
  logic                beat;
  logic                last_beat;

  assign prod      = {{DATA_W{1'b0}}, dataa} * {{DATA_W{1'b0}}, datab};
  assign acc_next  = acc + ACC_W'(prod);
  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (beat_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      beat_cnt  <= '0;
      acc       <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort outranks start here so a cancel can never launch a frame
          if (!abort && start) begin
            acc      <= '0;
            beat_cnt <= '0;
            busy     <= 1'b1;
            if (len != '0) begin
              len_q    <= len;
              in_ready <= 1'b1;
              state    <= RUN;
            end else begin
              result    <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          if (abort) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (beat) begin
            acc      <= acc_next;
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              result    <= acc_next;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
Sequencer that runs a 16x16 unsigned multiply-accumulate datapath as a framed dot-product engine. A host issues start with a vector length. The block clears the accumulator and accepts exactly that many operand pairs over a valid/ready stream. It then presents the 64-bit sum on a valid/ready result port and holds it until the result is taken. It sits between the operand source (FIFO or memory reader) and the MAC datapath, and owns accumulator clear and enable.

Parameters:
DATA_W, 16, operand width of dataa/datab
ACC_W, 64, accumulator/result width (must be >= 2*DATA_W)
LEN_W, 10, width of length field; max frame = 2^LEN_W-1 pairs

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame request; sampled only in IDLE
len  input  LEN_W  number of operand pairs in frame; sampled with start
abort  input  1  synchronous frame cancel
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operand pair
dataa  input  DATA_W  operand A (unsigned)
datab  input  DATA_W  operand B (unsigned)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  ACC_W  dot-product sum
busy  output  1  high in any state except IDLE
beat_cnt  output  LEN_W  pairs accepted in current frame

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=0, out_valid=0, busy=0, result=0, beat_cnt=0, accumulator=0, latched length=0. Reset mid-frame discards the frame with no out_valid.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 and len!=0: latch len, clear accumulator and beat_cnt, go to RUN next cycle.
  - start=1 and len==0: go to DONE with result=0.
  - in_ready=0 in IDLE.
- RUN:
  - in_ready=1.
  - Beat = in_valid & in_ready.
  - On a beat: acc <= acc + zero_extend(dataa*datab) (32-bit product, unsigned, mod 2^ACC_W), and beat_cnt increments.
  - in_valid=0 stalls indefinitely with no state change.
  - On the beat where beat_cnt == len-1: result <= updated acc, go to DONE. in_ready drops in the following cycle.
  - No additional pair is accepted beyond len.
- DONE:
  - out_valid=1; result stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: go to IDLE next cycle, out_valid=0.
  - result keeps its last value in IDLE until the next frame's DONE.
- Latency: result valid the cycle after the final beat. Throughput is 1 pair/cycle in RUN.
- start while busy: ignored, no queuing. start in the same cycle as the DONE handshake: ignored, because it is sampled only in IDLE.
- abort:
  - In RUN or DONE: return to IDLE next cycle, out_valid=0, accumulator unchanged.
  - In RUN, abort has priority over a simultaneous beat, and that beat is not accumulated.
  - In IDLE, abort has priority over start.
- Overflow cannot occur for ACC_W=64 and len<=1023; the wrap rule is stated for generality.
- beat_cnt holds its final value in DONE and clears on the next accepted start.

Test Plan:
- Basic frame:
  - Stimulus: reset, start with len=3, pairs (2,3),(4,5),(6,7) with in_valid held high.
  - Required: 3 beats on consecutive cycles; out_valid=1 the cycle after the 3rd beat; result=68; busy=1 from the cycle after start until the DONE handshake.
- Backpressure and stalls:
  - Stimulus: len=4, in_valid toggling 1,0,0,1,1,0,1 with pairs (65535,65535) ×4; out_ready held 0 for 5 cycles, then 1.
  - Required: result=17179344900 (4×4294836225), stable through all 5 stall cycles; IDLE one cycle after the handshake; beat_cnt=4 in DONE.
- Zero length and ignored start:
  - Stimulus: start with len=0.
  - Required: out_valid=1 with result=0, no beats accepted.
  - Stimulus: pulse start with len=5 while in DONE.
  - Required: the pulse is ignored, and the next frame's beat_cnt does not reflect len=5.
- Abort:
  - Stimulus: len=4; abort asserted together with the 2nd beat.
  - Required: IDLE next cycle, out_valid never asserts; the next frame (len=1, pair (9,9)) gives result=81.
- Async reset mid-frame:
  - Stimulus: deassert rst_n asynchronously after 2 of 5 beats.
  - Required: all outputs return to reset values immediately without waiting for a clock edge; a new frame (len=2, pairs (1,1),(1,1)) gives result=2.
- Back-to-back frames:
  - Stimulus: frame A (len=2, pairs (10,10),(10,10)), with start for frame B (len=1, pair (3,3)) asserted the cycle after the A handshake.
  - Required: A result=200 and B result=9; B's accumulator starts from 0.
